// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg -- shared constants for the signed restoring divider.
//
// Contents:
//   DIV_WIDTH        operand width the constants below are sized for
//   ITER             number of quotient-bit iterations (one per bit)
//   IDLE/RUN/DONE    FSM state encoding (2-bit, legacy-compatible constants)
//   MIN_NEG/NEG_ONE  operand pair that overflows signed division
//
// Imported by divider and div_step with import div_pkg::*.
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int ITER      = DIV_WIDTH;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    // -2^31 / -1 has no 32-bit signed quotient; it is flagged as overflow.
    localparam logic [DIV_WIDTH-1:0] MIN_NEG = 32'h8000_0000;
    localparam logic [DIV_WIDTH-1:0] NEG_ONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step -- one combinational restoring-division iteration.
//
// The remainder:quotient register is shifted left by one, |divisor| is
// trial-subtracted from the upper (remainder) half, and the difference is
// kept with quotient LSB=1 when it is non-negative; otherwise the shifted
// remainder is kept (restored) and the quotient LSB stays 0.
//
// Ports:
//   rq_in   [2*WIDTH:0]  remainder (upper WIDTH+1 bits) : quotient (lower WIDTH)
//   dvs     [WIDTH:0]    divisor magnitude (WIDTH+1 bits so 2^31 fits)
//   rq_out  [2*WIDTH:0]  register value after this iteration
// ---------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [2*WIDTH:0] rq_in,
    input  logic [WIDTH:0]   dvs,
    output logic [2*WIDTH:0] rq_out
);

    logic [2*WIDTH+1:0] shifted;
    logic [WIDTH+1:0]   upper;
    logic [WIDTH+1:0]   diff;

    always_comb begin
        shifted = {rq_in, 1'b0};
        // The remainder is always below |divisor| <= 2^31, so after the shift
        // it still fits in WIDTH+1 bits; one extra bit carries the sign of the
        // trial subtraction.
        upper   = shifted[2*WIDTH+1:WIDTH];
        diff    = upper - {1'b0, dvs};
        if (!diff[WIDTH+1]) begin
            rq_out = {diff[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
        end else begin
            rq_out = shifted[2*WIDTH:0];
        end
    end

endmodule

// File: rtl/divider.sv
// ---------------------------------------------------------------------------
// divider -- multi-cycle signed 32-bit divider (restoring, radix-2).
//
// Computes dividend / divisor with the quotient truncated toward zero. The
// operands are converted to magnitudes when start is accepted, one quotient
// bit is produced per clock, and the sign is applied on the cycle that
// enters DONE.
//
// Latency: start sampled at edge E0, iterations on E1..E32, sign correction
// and ready on E33. Divide-by-zero and the -2^31 / -1 overflow finish at E1
// with exception=1.
//
// Ports:
//   clk         clock, rising edge
//   clr         asynchronous active-high reset; clears all state
//   start       one-cycle request, accepted in IDLE or DONE, ignored in RUN
//   dividend    signed numerator, sampled at acceptance only
//   divisor     signed denominator, sampled at acceptance only
//   result      signed quotient, valid while ready=1, 0 while running
//   exception   divide-by-zero / overflow flag, valid while ready=1
//   ready       high in DONE until the next accepted start or clr
//   remainder   signed remainder (only when DIVIDER_REMAINDER_EN is defined),
//               sign follows the dividend, 0 on exception
//   state_dbg   current FSM state (IDLE/RUN/DONE encoding from div_pkg)
//
// Handshake: start is a request pulse with no backpressure. It is taken on a
// rising edge whenever the FSM is in IDLE or DONE (including the cycle where
// ready=1, which drops on that same edge) and is ignored in RUN and while clr
// is high. ready=1 marks result/exception (and remainder) as valid and they
// hold until the next accepted start.
//
// Configuration macro: DIVIDER_REMAINDER_EN adds the remainder output and
// its sign-fix logic.
// ---------------------------------------------------------------------------
module divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             ready,
`ifdef DIVIDER_REMAINDER_EN
    output logic [WIDTH-1:0] remainder,
`endif
    output logic [1:0]       state_dbg
);

    localparam int             CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0]  LAST = CW'(ITER);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [2*WIDTH:0] rq;
    logic [2*WIDTH:0] rq_next;
    logic [WIDTH:0]   dvs_mag;
    logic             q_neg;
    logic             dz;
    logic             ovf;
`ifdef DIVIDER_REMAINDER_EN
    logic             r_neg;
    logic [WIDTH-1:0] rem_mag;
`endif

    // Operand magnitudes in WIDTH+1 bits: -2^31 sign-extends to 33 bits and
    // negates to the unsigned value 2^31 without wrapping.
    logic [WIDTH:0]   dd_ext;
    logic [WIDTH:0]   dv_ext;
    logic [WIDTH:0]   dd_mag;
    logic [WIDTH:0]   dv_mag;
    logic [WIDTH-1:0] q_bits;

    always_comb begin
        dd_ext = {dividend[WIDTH-1], dividend};
        dv_ext = {divisor[WIDTH-1], divisor};
        dd_mag = dd_ext[WIDTH] ? -dd_ext : dd_ext;
        dv_mag = dv_ext[WIDTH] ? -dv_ext : dv_ext;
        q_bits = rq[WIDTH-1:0];
    end

`ifdef DIVIDER_REMAINDER_EN
    // The final remainder is below |divisor| <= 2^31, so WIDTH bits suffice.
    always_comb begin
        rem_mag = rq[2*WIDTH-1:WIDTH];
    end
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rq_in  (rq),
        .dvs    (dvs_mag),
        .rq_out (rq_next)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            cnt       <= '0;
            rq        <= '0;
            dvs_mag   <= '0;
            q_neg     <= 1'b0;
            dz        <= 1'b0;
            ovf       <= 1'b0;
            result    <= '0;
            exception <= 1'b0;
            ready     <= 1'b0;
`ifdef DIVIDER_REMAINDER_EN
            r_neg     <= 1'b0;
            remainder <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        cnt       <= '0;
                        // dd_mag[WIDTH] is always 0; it lands in the remainder
                        // LSB, which must start at zero anyway.
                        rq        <= {{WIDTH{1'b0}}, dd_mag};
                        dvs_mag   <= dv_mag;
                        q_neg     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        dz        <= (divisor == '0);
                        ovf       <= (dividend == MIN_NEG) && (divisor == NEG_ONE);
                        result    <= '0;
                        exception <= 1'b0;
                        ready     <= 1'b0;
`ifdef DIVIDER_REMAINDER_EN
                        r_neg     <= dividend[WIDTH-1];
                        remainder <= '0;
`endif
                    end
                end

                RUN: begin
                    if (dz || ovf) begin
                        // Early-out: the quotient is not computed at all.
                        state     <= DONE;
                        result    <= dz ? '0 : MIN_NEG;
                        exception <= 1'b1;
                        ready     <= 1'b1;
`ifdef DIVIDER_REMAINDER_EN
                        remainder <= '0;
`endif
                    end else if (cnt == LAST) begin
                        // All quotient bits done: apply signs and publish.
                        state     <= DONE;
                        result    <= q_neg ? -q_bits : q_bits;
                        exception <= 1'b0;
                        ready     <= 1'b1;
`ifdef DIVIDER_REMAINDER_EN
                        remainder <= r_neg ? -rem_mag : rem_mag;
`endif
                    end else begin
                        rq  <= rq_next;
                        cnt <= cnt + CW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_divider.sv
// ---------------------------------------------------------------------------
// tb_divider -- self-checking bench for divider.
//
// Expected results come from a behavioural model built on SystemVerilog's
// signed / and % (both truncate toward zero). They are queued when a start is
// driven and popped when ready rises. Remainder checks are compiled in when
// DIVIDER_REMAINDER_EN is defined.
// ---------------------------------------------------------------------------
module tb_divider;
    import div_pkg::*;

    logic        clk;
    logic        clr;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] result;
    logic        exception;
    logic        ready;
    logic [1:0]  state_dbg;
`ifdef DIVIDER_REMAINDER_EN
    logic [31:0] remainder;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    logic        exc_q[$];
    logic [31:0] rem_q[$];
    int          lat_q[$];
    logic [31:0] last_q;

    divider #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .result    (result),
        .exception (exception),
        .ready     (ready),
`ifdef DIVIDER_REMAINDER_EN
        .remainder (remainder),
`endif
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model(input logic [31:0] dd, input logic [31:0] dv,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic e, output int lat);
        logic signed [31:0] sd;
        logic signed [31:0] sv;
        sd = dd;
        sv = dv;
        if (dv == 32'd0) begin
            q = 32'd0; r = 32'd0; e = 1'b1; lat = 1;
        end else if (dd == 32'h8000_0000 && dv == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0; e = 1'b1; lat = 1;
        end else begin
            q = sd / sv; r = sd % sv; e = 1'b0; lat = 33;
        end
    endtask

    // ---------------- driver ----------------
    // poke > 0: drive a different start request during RUN after that many
    // edges past acceptance. b2b: the request is issued while ready=1.
    task automatic run_op(input logic [31:0] dd, input logic [31:0] dv,
                          input int poke, input bit b2b);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ee;
        int          el;
        int          cycles;
        bit          loud;
        logic [31:0] got_q;
        logic        got_e;
        logic [31:0] got_r;
        int          got_l;

        model(dd, dv, eq, er, ee, el);
        exp_q.push_back(eq);
        exc_q.push_back(ee);
        rem_q.push_back(er);
        lat_q.push_back(el);

        @(negedge clk);
        if (b2b) check("b2b_ready_before", {31'd0, ready}, 32'd1);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        // Operands must have been latched; scramble the inputs.
        dividend = $urandom;
        divisor  = $urandom;
        check("accept_ready_low", {31'd0, ready}, 32'd0);
        check("accept_state_run", {30'd0, state_dbg}, {30'd0, RUN});

        cycles = 0;
        loud   = 1'b0;
        while (ready !== 1'b1 && cycles < 60) begin
            if (result !== 32'd0 || exception !== 1'b0) loud = 1'b1;
            @(negedge clk);
            if (poke > 0 && cycles == poke) begin
                start    = 1'b1;
                dividend = dd ^ 32'h0000_5A5A;
                divisor  = dv + 32'd3;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cycles++;
        end

        got_q = exp_q.pop_front();
        got_e = exc_q.pop_front();
        got_r = rem_q.pop_front();
        got_l = lat_q.pop_front();
        last_q = got_q;
        check("latency", 32'(cycles), 32'(got_l));
        check("run_quiet", {31'd0, loud}, 32'd0);
        check("result", result, got_q);
        check("exception", {31'd0, exception}, {31'd0, got_e});
        check("done_state", {30'd0, state_dbg}, {30'd0, DONE});
`ifdef DIVIDER_REMAINDER_EN
        check("remainder", remainder, got_r);
`endif
    endtask

    task automatic count_ready(input int n, output int hits);
        hits = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (ready !== 1'b0) hits++;
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int hits;
        int kind;
        logic [31:0] a;
        logic [31:0] b;

        clr      = 1'b1;
        start    = 1'b1;   // coincident with clr: must be ignored
        dividend = 32'd100;
        divisor  = 32'd7;
        last_q   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_exception", {31'd0, exception}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, {30'd0, IDLE});
`ifdef DIVIDER_REMAINDER_EN
        check("rst_remainder", remainder, 32'd0);
`endif
        @(negedge clk);
        clr   = 1'b0;
        start = 1'b0;
        count_ready(40, hits);
        check("start_under_clr_ignored", 32'(hits), 32'd0);

        // Basic signs
        run_op(32'd100, 32'd7, 0, 1'b0);
        // result must hold while idling in DONE
        repeat (3) @(posedge clk);
        #1;
        check("hold_ready", {31'd0, ready}, 32'd1);
        check("hold_result", result, last_q);
        run_op(-32'sd100, 32'd7, 0, 1'b1);
        run_op(32'd100, -32'sd7, 0, 1'b1);
        run_op(-32'sd100, -32'sd7, 0, 1'b1);

        // Exceptions and boundaries
        run_op(32'd5, 32'd0, 0, 1'b1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
        run_op(32'd0, 32'd5, 0, 1'b1);
        run_op(32'h8000_0000, 32'd1, 0, 1'b1);
        run_op(32'h8000_0000, 32'd2, 0, 1'b1);
        run_op(32'h8000_0000, 32'h8000_0000, 0, 1'b1);
        run_op(32'd7, 32'h8000_0000, 0, 1'b1);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1);
        run_op(32'h7FFF_FFFF, 32'd1, 0, 1'b1);
        run_op(32'd3, 32'd7, 0, 1'b1);

        // Start during RUN is ignored; original quotient returned
        run_op(32'd1000, 32'd3, 5, 1'b0);

        // clr while DONE clears outputs immediately
        @(negedge clk);
        #2;
        clr = 1'b1;
        #1;
        check("clr_async_ready", {31'd0, ready}, 32'd0);
        check("clr_async_result", result, 32'd0);
        check("clr_async_state", {30'd0, state_dbg}, {30'd0, IDLE});
        @(negedge clk);
        clr = 1'b0;

        // clr mid-RUN aborts; no ready afterwards until a new start
        @(negedge clk);
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(posedge clk);
        #2;
        clr = 1'b1;
        #1;
        check("abort_ready", {31'd0, ready}, 32'd0);
        check("abort_state", {30'd0, state_dbg}, {30'd0, IDLE});
        @(negedge clk);
        clr = 1'b0;
        count_ready(40, hits);
        check("abort_no_ready", 32'(hits), 32'd0);
        run_op(32'd9, 32'd3, 0, 1'b0);

        // Random signed sweep, divisor never zero
        for (int i = 0; i < 1500; i++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin a = $urandom; b = $urandom; end
                1: begin
                    a = 32'($urandom_range(0, 100)) - 32'd50;
                    b = 32'($urandom_range(0, 100)) - 32'd50;
                end
                2: begin a = $urandom; b = 32'($urandom_range(0, 40)) - 32'd20; end
                default: begin
                    case ($urandom_range(0, 3))
                        0: a = 32'h8000_0000;
                        1: a = 32'h7FFF_FFFF;
                        2: a = 32'hFFFF_FFFF;
                        default: a = 32'd0;
                    endcase
                    b = $urandom_range(0, 1) == 1 ? $urandom : 32'hFFFF_FFFF;
                end
            endcase
            if (b == 32'd0) b = 32'd1;
            run_op(a, b, 0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
